// File: rtl/dmem_responder.sv
// dmem_responder: fixed-latency, word-addressed data memory model that sits
// below the L2 cache. It accepts one load or store at a time and answers with
// a one-cycle response pulse after LATENCY cycles.
module dmem_responder #(
  parameter int DEPTH   = 1024,  // 32-bit words, power of 2
  parameter int LATENCY = 4      // accept-to-response cycles, 1..15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [6:0]  opcode_in,
  input  logic [31:0] addr,
  input  logic [31:0] data_from_L2,
  output logic        resp_valid,
  output logic [31:0] data_from_dmem,
  output logic        addr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [3:0]      cnt;
  logic            is_store_q;
  logic            err_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [DEPTH];
  logic            accept;
  logic            enter_resp;
  logic            addr_oor;
  logic            unused_addr_bits;

  // Byte offset within the word carries no meaning for a word array.
  assign unused_addr_bits = ^addr[1:0];

  // Only loads and stores are accepted; any other opcode is silently dropped.
  assign accept   = (state == IDLE) && req_valid &&
                    ((opcode_in == OP_LOAD) || (opcode_in == OP_STORE));
  assign addr_oor = ({2'b00, addr[31:2]} >= 32'(DEPTH));

  // Next-state decode; enter_resp marks the edge on which the access happens.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_next = state;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd1) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Request capture on handshake and latency countdown while busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      is_store_q <= 1'b0;
      err_q      <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
    end else if (accept) begin
      cnt        <= 4'(LATENCY - 1);
      is_store_q <= (opcode_in == OP_STORE);
      err_q      <= addr_oor;
      idx_q      <= addr[AW+1:2];
      wdata_q    <= data_from_L2;
    end else if (state == BUSY) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Array: cleared on reset, written by in-range stores entering RESP.
  always_ff @(posedge clk) begin
    // NOTE: the array must read back zero after reset, so it is built from
    // resettable flops rather than a RAM macro that has no reset.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (enter_resp && is_store_q && !err_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  // Load data register: updated only by load responses, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (enter_resp && !is_store_q) begin
      rdata_q <= err_q ? 32'd0 : mem[idx_q];
    end
  end

  assign req_ready      = (state == IDLE);
  assign resp_valid     = (state == RESP);
  assign addr_err       = (state == RESP) && err_q;
  assign data_from_dmem = rdata_q;

endmodule
